// File: rtl/axis_frame_tag_writer.sv
// AXI4-Stream framer: tags each accepted sample with {misc, in-frame index}; one-cycle registered output, no bubbles.
// Backpressure passes straight to s_axis_tready. Optional SOF flag on m_axis_tuser via AXIS_FRAME_TAG_WRITER_SOF_EN.
module axis_frame_tag_writer #(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH         = 16,
  parameter int MISC_WIDTH         = 16,
  parameter int FRAME_CNTR_WIDTH   = 16,
  localparam int M_AXIS_TDATA_WIDTH = MISC_WIDTH + CNTR_WIDTH + S_AXIS_TDATA_WIDTH
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [CNTR_WIDTH-1:0]         cfg_data,
  input  logic [FRAME_CNTR_WIDTH-1:0]   cfg_frames,
  input  logic [MISC_WIDTH-1:0]         misc_data,
  input  logic                          start,
  input  logic                          stop,
  output logic                          s_axis_tready,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic [FRAME_CNTR_WIDTH-1:0]   frame_cntr
`ifdef AXIS_FRAME_TAG_WRITER_SOF_EN
  ,
  output logic                          m_axis_tuser
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;

  logic [CNTR_WIDTH-1:0]           r_len_lat;
  logic [MISC_WIDTH-1:0]           r_misc_lat;
  logic [FRAME_CNTR_WIDTH-1:0]     r_frames_lat;
  logic [CNTR_WIDTH-1:0]           r_sample_idx;
  logic [FRAME_CNTR_WIDTH-1:0]     r_frame_cntr;
  logic                            r_stop_pend;

  logic [M_AXIS_TDATA_WIDTH-1:0]   r_m_tdata;
  logic                            r_m_tvalid;
  logic                            r_m_tlast;

  logic                            w_out_free;
  logic                            w_accept;
  logic                            w_idx_at_end;
  logic                            w_frame_end;
  logic [FRAME_CNTR_WIDTH-1:0]     w_frame_cntr_inc;
  logic                            w_last_frame;

  // Output register can take a new word when empty or being drained this cycle.
  assign w_out_free       = ~r_m_tvalid | m_axis_tready;
  assign s_axis_tready    = (r_state == ST_RUN) & w_out_free;
  assign w_accept         = s_axis_tvalid & s_axis_tready;
  assign w_idx_at_end     = (r_sample_idx == r_len_lat);
  assign w_frame_end      = w_accept & w_idx_at_end;
  assign w_frame_cntr_inc = r_frame_cntr + 1'b1;
  assign w_last_frame     = (r_frames_lat != '0) && (w_frame_cntr_inc == r_frames_lat);

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign busy          = (r_state != ST_IDLE);
  assign frame_cntr    = r_frame_cntr;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A stop arriving with the frame-end sample still ends the run after this frame.
        if (w_frame_end && (r_stop_pend || stop || w_last_frame)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_out_free) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_len_lat    <= '0;
      r_misc_lat   <= '0;
      r_frames_lat <= '0;
      r_sample_idx <= '0;
      r_frame_cntr <= '0;
      r_stop_pend  <= 1'b0;
    end else begin
      if (r_state == ST_RUN) begin
        r_stop_pend <= r_stop_pend | stop;
      end else begin
        r_stop_pend <= 1'b0;
      end

      if ((r_state == ST_IDLE) && start) begin
        r_len_lat    <= cfg_data;
        r_misc_lat   <= misc_data;
        r_frames_lat <= cfg_frames;
        r_sample_idx <= '0;
        r_frame_cntr <= '0;
      end else if (w_accept) begin
        if (w_idx_at_end) begin
          r_sample_idx <= '0;
          r_frame_cntr <= w_frame_cntr_inc;
          r_len_lat    <= cfg_data;
          r_misc_lat   <= misc_data;
        end else begin
          r_sample_idx <= r_sample_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tdata  <= {r_misc_lat, r_sample_idx, s_axis_tdata};
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_idx_at_end;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_FRAME_TAG_WRITER_SOF_EN
  logic r_m_tuser;

  assign m_axis_tuser = r_m_tuser;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_m_tuser <= 1'b0;
    end else if (w_accept) begin
      r_m_tuser <= (r_sample_idx == '0);
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_tag_writer.sv
// Randomized bench for axis_frame_tag_writer: scoreboard built from the framing rules, stall-stability and end-of-run checks.
module tb_axis_frame_tag_writer;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] cfg_data;
  logic [15:0] cfg_frames;
  logic [15:0] misc_data;
  logic        start;
  logic        stop;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        busy;
  logic [15:0] frame_cntr;
`ifdef AXIS_FRAME_TAG_WRITER_SOF_EN
  logic        m_axis_tuser;
`endif

  axis_frame_tag_writer dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_data      (cfg_data),
    .cfg_frames    (cfg_frames),
    .misc_data     (misc_data),
    .start         (start),
    .stop          (stop),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_cntr    (frame_cntr)
`ifdef AXIS_FRAME_TAG_WRITER_SOF_EN
    ,
    .m_axis_tuser  (m_axis_tuser)
`endif
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: expected output words in acceptance order.
  logic [64:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          m_len;
  logic [15:0] m_tag;
  int          m_idx;
  int          m_frames;
  int          in_cnt;
  int          out_cnt;
  bit          stall_prev;
  logic [63:0] prev_tdata;
  logic        prev_tlast;
  bit          last_in_hs;

  always @(negedge aclk) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_vld", {63'd0, m_axis_tvalid}, 64'd1);
        check("stall_dat", m_axis_tdata, prev_tdata);
        check("stall_lst", {63'd0, m_axis_tlast}, {63'd0, prev_tlast});
      end
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back({(m_idx == m_len), m_tag, 16'(m_idx), s_axis_tdata});
        in_cnt++;
        if (m_idx == m_len) begin
          m_idx = 0;
          m_frames++;
          m_tag = misc_data;
        end else begin
          m_idx++;
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_out", m_axis_tdata, 64'hx);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("out_dat", m_axis_tdata, e[63:0]);
          check("out_lst", {63'd0, m_axis_tlast}, {63'd0, e[64]});
`ifdef AXIS_FRAME_TAG_WRITER_SOF_EN
          check("out_sof", {63'd0, m_axis_tuser}, {63'd0, (e[47:32] == 16'd0)});
`endif
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_tdata = m_axis_tdata;
      prev_tlast = m_axis_tlast;
      last_in_hs = s_axis_tvalid && s_axis_tready;
    end
  end

  // rmode: 0 ready always, 1 toggling, 2 random. vmode: 0 continuous valid, 1 random.
  task automatic run_case(input int len, input int frames, input logic [15:0] tag,
                          input int rmode, input int vmode, input int stop_frame,
                          input int start_hold, input bit tag_change);
    int  cyc;
    bit  done;
    bit  stop_sent;
    bit  tag_sent;
    int  exp_frames;
    exp_frames = (frames != 0) ? frames : stop_frame;
    exp_q.delete();
    m_len = len; m_tag = tag; m_idx = 0; m_frames = 0;
    in_cnt = 0; out_cnt = 0; stall_prev = 1'b0; last_in_hs = 1'b0;
    cfg_data = 16'(len); cfg_frames = 16'(frames); misc_data = tag;
    start = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    mon_en = 1'b1;
    cyc = 0; done = 1'b0; stop_sent = 1'b0; tag_sent = 1'b0;
    while (!done) begin
      @(posedge aclk); #1;
      cyc++;
      stop = 1'b0;
      if (cyc == 1) check("busy_on", {63'd0, busy}, 64'd1);
      if (cyc >= start_hold) start = 1'b0;
      if (cyc > 1 && !busy) begin
        done = 1'b1;
      end else if (cyc > 3000) begin
        check("timeout", {63'd0, busy}, 64'd0);
        done = 1'b1;
      end
      if (!s_axis_tvalid || last_in_hs) begin
        s_axis_tvalid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        s_axis_tdata  = $urandom;
      end
      case (rmode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 2) != 0);
      endcase
      if (stop_frame > 0 && !stop_sent && m_frames == stop_frame - 1) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end
      if (tag_change && !tag_sent && m_frames == 2 && m_idx == 1) begin
        misc_data = 16'h1234;
        tag_sent = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
    stop = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    mon_en = 1'b0;
    check("in_cnt", 64'(in_cnt), 64'(exp_frames * (len + 1)));
    check("out_cnt", 64'(out_cnt), 64'(exp_frames * (len + 1)));
    check("q_empty", 64'(exp_q.size()), 64'd0);
    check("frm_cntr", {48'd0, frame_cntr}, 64'(exp_frames));
    check("idle_bsy", {63'd0, busy}, 64'd0);
    check("idle_rdy", {63'd0, s_axis_tready}, 64'd0);
    check("idle_vld", {63'd0, m_axis_tvalid}, 64'd0);
  endtask

  initial begin
    areset = 1'b1;
    cfg_data = '0; cfg_frames = '0; misc_data = '0;
    start = 1'b0; stop = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_vld", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_rdy", {63'd0, s_axis_tready}, 64'd0);
    check("rst_bsy", {63'd0, busy}, 64'd0);
    check("rst_dat", m_axis_tdata, 64'd0);
    check("rst_lst", {63'd0, m_axis_tlast}, 64'd0);
    check("rst_frm", {48'd0, frame_cntr}, 64'd0);
    areset = 1'b0;
    @(posedge aclk); #1;

    // Basic two-frame run, then same with toggling ready and random traffic.
    run_case(3, 2, 16'hABCD, 0, 0, 0, 1, 1'b0);
    run_case(3, 2, 16'hABCD, 1, 0, 0, 1, 1'b0);
    run_case(5, 3, 16'h5A5A, 2, 1, 0, 1, 1'b0);
    // Continuous mode with mid-frame tag change and stop during frame 5.
    run_case(1, 0, 16'h0F0F, 2, 1, 5, 1, 1'b1);
    // Single-sample frames.
    run_case(0, 3, 16'h7777, 2, 1, 0, 1, 1'b0);

    // Reset mid-frame with data pending in the output register.
    cfg_data = 16'd1; cfg_frames = 16'd0; misc_data = 16'h4444;
    start = 1'b1; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    repeat (7) begin
      s_axis_tdata = $urandom;
      @(posedge aclk); #1;
    end
    check("pre_rst_frm", {63'd0, (frame_cntr != 16'd0)}, 64'd1);
    areset = 1'b1; m_axis_tready = 1'b0;
    @(posedge aclk); #1;
    check("mrst_vld", {63'd0, m_axis_tvalid}, 64'd0);
    check("mrst_rdy", {63'd0, s_axis_tready}, 64'd0);
    check("mrst_bsy", {63'd0, busy}, 64'd0);
    check("mrst_frm", {48'd0, frame_cntr}, 64'd0);
    areset = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    @(posedge aclk); #1;
    run_case(2, 2, 16'h9999, 2, 1, 0, 1, 1'b0);

    // Stop pulsed in IDLE, then start held high well into the run.
    stop = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    stop = 1'b0;
    check("stop_idle_bsy", {63'd0, busy}, 64'd0);
    run_case(2, 2, 16'hC0DE, 2, 1, 0, 4, 1'b0);
    run_case(4, 4, 16'h2468, 2, 1, 0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
